// File: rtl/video_stream_monitor.sv
`default_nettype none
// video_stream_monitor: recovers pixel coordinates from a raw sync/DE video stream and checks
// per-frame geometry. Optional pixel checksum: VIDEO_MON_CHECKSUM_EN. Rev 1.0
module video_stream_monitor #(
  parameter int H_ACTIVE  = 800,
  parameter int V_ACTIVE  = 600,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        disp_enbl,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic [10:0] rx_sx,
  output logic [9:0]  rx_sy,
  output logic        rx_de,
  output logic [11:0] rx_rgb,
  output logic        frame_done,
  output logic [10:0] frame_w,
  output logic [9:0]  frame_h,
  output logic        geom_err,
  output logic        locked,
  output logic [15:0] frame_cnt,
  output logic [31:0] frame_sum
);

  localparam logic [10:0] H_EXP  = 11'(H_ACTIVE);
  localparam logic [9:0]  V_EXP  = 10'(V_ACTIVE);
  localparam logic [10:0] SX_MAX = 11'h7FF;
  localparam logic [9:0]  SY_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    WAIT_VSYNC = 2'd0,
    WAIT_LINE  = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  state_t state, state_next;

  // Syncs are stored already normalised, so reset (0) means "inactive".
  logic        hs_q, vs_q, de_q;
  logic        hs_d, vs_d, de_d;
  logic [11:0] rgb_q;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      de_q  <= 1'b0;
      hs_d  <= 1'b0;
      vs_d  <= 1'b0;
      de_d  <= 1'b0;
      rgb_q <= 12'd0;
    end else begin
      hs_q  <= (h_sync == HSYNC_POL);
      vs_q  <= (v_sync == VSYNC_POL);
      de_q  <= disp_enbl;
      hs_d  <= hs_q;
      vs_d  <= vs_q;
      de_d  <= de_q;
      rgb_q <= {red, green, blue};
    end
  end

  logic vs_rise, hs_rise, de_rise, de_fall;
  assign vs_rise = vs_q & ~vs_d;
  assign hs_rise = hs_q & ~hs_d;
  assign de_rise = de_q & ~de_d;
  assign de_fall = ~de_q & de_d;

  logic line_start, line_done, truncate, finish, pix_valid;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) state <= WAIT_VSYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    line_start = 1'b0;
    line_done  = 1'b0;
    truncate   = 1'b0;
    finish     = 1'b0;
    case (state)
      WAIT_VSYNC: begin
        if (vs_rise) state_next = WAIT_LINE;
      end
      WAIT_LINE: begin
        if (vs_rise) begin
          finish = 1'b1;
        end else if (de_rise) begin
          line_start = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        // A line ending on the same cycle as vs_rise still belongs to this frame.
        line_done = de_fall;
        if (vs_rise) begin
          finish     = 1'b1;
          truncate   = de_q;
          state_next = WAIT_LINE;
        end else if (de_fall) begin
          state_next = WAIT_LINE;
        end
      end
      default: state_next = WAIT_VSYNC;
    endcase
  end

  assign pix_valid = de_q & ~vs_rise & ((state == ACTIVE) | line_start);

  logic [10:0] width_cnt, last_width, last_width_nx;
  logic [9:0]  line_cnt, line_cnt_nx;
  logic        width_err, width_err_nx, line_ovf, line_ovf_nx, frame_bad;

  always_comb begin
    line_cnt_nx   = line_cnt;
    line_ovf_nx   = line_ovf;
    last_width_nx = last_width;
    width_err_nx  = width_err;
    if (line_done) begin
      last_width_nx = width_cnt;
      if (line_cnt == SY_MAX) line_ovf_nx = 1'b1;
      else                    line_cnt_nx = line_cnt + 10'd1;
      if (width_cnt != H_EXP) width_err_nx = 1'b1;
    end
    if (truncate || (hs_rise && (((state == ACTIVE) && de_q) || line_start)))
      width_err_nx = 1'b1;
    frame_bad = width_err_nx | line_ovf_nx | (line_cnt_nx != V_EXP);
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      width_cnt  <= 11'd0;
      last_width <= 11'd0;
      line_cnt   <= 10'd0;
      width_err  <= 1'b0;
      line_ovf   <= 1'b0;
      frame_done <= 1'b0;
      frame_w    <= 11'd0;
      frame_h    <= 10'd0;
      geom_err   <= 1'b0;
      locked     <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      frame_done <= finish;
      if (line_start)
        width_cnt <= 11'd1;
      else if (pix_valid && (width_cnt != SX_MAX))
        width_cnt <= width_cnt + 11'd1;
      if (finish) begin
        frame_w    <= last_width_nx;
        frame_h    <= line_cnt_nx;
        geom_err   <= frame_bad;
        locked     <= ~frame_bad;
        frame_cnt  <= frame_cnt + 16'd1;
        last_width <= 11'd0;
        line_cnt   <= 10'd0;
        width_err  <= 1'b0;
        line_ovf   <= 1'b0;
      end else begin
        last_width <= last_width_nx;
        line_cnt   <= line_cnt_nx;
        width_err  <= width_err_nx;
        line_ovf   <= line_ovf_nx;
      end
    end
  end

  // Coordinates follow the stream itself, independent of frame lock state.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      rx_sx  <= 11'd0;
      rx_sy  <= 10'd0;
      rx_de  <= 1'b0;
      rx_rgb <= 12'd0;
    end else begin
      rx_de  <= de_q;
      rx_rgb <= rgb_q;
      if (de_q) begin
        if (!de_d)                rx_sx <= 11'd0;
        else if (rx_sx != SX_MAX) rx_sx <= rx_sx + 11'd1;
      end else if (de_fall) begin
        rx_sx <= 11'd0;
      end
      if (vs_rise)
        rx_sy <= 10'd0;
      else if (de_fall && (rx_sy != SY_MAX))
        rx_sy <= rx_sy + 10'd1;
    end
  end

`ifdef VIDEO_MON_CHECKSUM_EN
  logic [31:0] sum_acc;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      sum_acc   <= 32'd0;
      frame_sum <= 32'd0;
    end else if (finish) begin
      frame_sum <= sum_acc;
      sum_acc   <= 32'd0;
    end else if (pix_valid) begin
      sum_acc <= sum_acc + {20'd0, rgb_q};
    end
  end
`else
  assign frame_sum = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_stream_monitor.sv
`default_nettype none
// tb_video_stream_monitor: scaled-geometry frames driven cycle by cycle, per-cycle and per-frame scoreboard.
module tb_video_stream_monitor;

  localparam int HA = 20;
  localparam int VA = 8;
  localparam int HT = 28;
  localparam int VT = 11;
`ifdef VIDEO_MON_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        h_sync = 1'b0;
  logic        v_sync = 1'b1;
  logic        disp_enbl = 1'b0;
  logic [3:0]  red = 4'd0, green = 4'd0, blue = 4'd0;
  logic [10:0] rx_sx;
  logic [9:0]  rx_sy;
  logic        rx_de;
  logic [11:0] rx_rgb;
  logic        frame_done;
  logic [10:0] frame_w;
  logic [9:0]  frame_h;
  logic        geom_err;
  logic        locked;
  logic [15:0] frame_cnt;
  logic [31:0] frame_sum;

  video_stream_monitor #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .HSYNC_POL(1'b1),
    .VSYNC_POL(1'b0)
  ) dut (
    .pixel_clk (clk),
    .rst_n     (rst_n),
    .h_sync    (h_sync),
    .v_sync    (v_sync),
    .disp_enbl (disp_enbl),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .rx_sx     (rx_sx),
    .rx_sy     (rx_sy),
    .rx_de     (rx_de),
    .rx_rgb    (rx_rgb),
    .frame_done(frame_done),
    .frame_w   (frame_w),
    .frame_h   (frame_h),
    .geom_err  (geom_err),
    .locked    (locked),
    .frame_cnt (frame_cnt),
    .frame_sum (frame_sum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        de;
    logic [10:0] sx;
    logic [9:0]  sy;
    logic [11:0] rgb;
    logic        done;
  } rec_t;

  typedef struct {
    bit          chk_w;
    int          w;
    int          h;
    bit          err;
    int          cnt;
    logic [31:0] sum;
  } fexp_t;

  typedef struct {
    int n_lines;
    int short_idx;
    int short_len;
    int vs_line;
    int vs_px;
    int hs_idx;
    bit solid;
    int exp_done;
    bit chk_w;
    int exp_w;
    int exp_h;
    bit exp_err;
  } frame_vec_t;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  rec_t  sbq[$];
  fexp_t fq[$];
  fexp_t cur_exp;

  logic [10:0] m_sx;
  logic [9:0]  m_sy;
  logic        m_pde, m_pvs, m_armed, m_line_ok;
  logic [31:0] m_acc;
  int          exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sx = 11'd0; m_sy = 10'd0; m_pde = 1'b0; m_pvs = 1'b0;
    m_armed = 1'b0; m_line_ok = 1'b0; m_acc = 32'd0; exp_cnt = 0;
  endtask

  task automatic step(input logic r, input logic hs, input logic vs, input logic de,
                      input logic [11:0] rgb);
    rec_t  e;
    fexp_t f;
    logic  vr, dr, df, pv;
    rst_n = r; h_sync = hs; v_sync = ~vs; disp_enbl = de; {red, green, blue} = rgb;
    e = '0;
    if (!r) begin
      model_reset();
      sbq.delete();
      fq.delete();
      sbq.push_back(e);
    end else begin
      vr = vs & ~m_pvs;
      dr = de & ~m_pde;
      df = ~de & m_pde;
      if (de) m_sx = m_pde ? ((m_sx == 11'h7FF) ? m_sx : m_sx + 11'd1) : 11'd0;
      else if (df) m_sx = 11'd0;
      if (vr) m_sy = 10'd0;
      else if (df && m_sy != 10'h3FF) m_sy = m_sy + 10'd1;
      pv = de & ~vr & m_armed & (m_pde ? m_line_ok : 1'b1);
      if (pv) m_acc = m_acc + {20'd0, rgb};
      if (vr) m_line_ok = 1'b0;
      else if (dr && m_armed) m_line_ok = 1'b1;
      else if (!de) m_line_ok = 1'b0;
      e.done = vr & m_armed;
      if (e.done) begin
        exp_cnt++;
        f = cur_exp;
        f.cnt = exp_cnt;
        f.sum = CSUM_EN ? m_acc : 32'd0;
        fq.push_back(f);
        m_acc = 32'd0;
      end
      if (vr) m_armed = 1'b1;
      m_pde = de; m_pvs = vs;
      e.de = de; e.sx = m_sx; e.sy = m_sy; e.rgb = rgb;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sbq.size() == 2) begin
      e = sbq.pop_front();
      checks++;
      if ({rx_de, rx_sx, rx_sy, rx_rgb, frame_done} !== e) begin
        errors++;
        $display("FAIL stream @%0t: got de=%b sx=%0d sy=%0d rgb=%h done=%b expected de=%b sx=%0d sy=%0d rgb=%h done=%b",
                 $time, rx_de, rx_sx, rx_sy, rx_rgb, frame_done, e.de, e.sx, e.sy, e.rgb, e.done);
      end
    end
    if (frame_done) begin
      done_seen++;
      if (fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_done: got unexpected pulse expected none (frame_cnt=%0d)", frame_cnt);
      end else begin
        f = fq.pop_front();
        if (f.chk_w) chk("frame_w", 32'(frame_w), f.w);
        chk("frame_h", 32'(frame_h), f.h);
        chk("geom_err", 32'(geom_err), 32'(f.err));
        chk("locked", 32'(locked), 32'(!f.err));
        chk("frame_cnt", 32'(frame_cnt), f.cnt);
        chk("frame_sum", frame_sum, f.sum);
      end
    end
  endtask

  task automatic gen_frame(input frame_vec_t v, input int stop_after);
    int   n;
    int   pos, vs0, len;
    logic hs, vs, de;
    logic [3:0] lnb, hb;
    n = 0;
    cur_exp.chk_w = v.chk_w; cur_exp.w = v.exp_w; cur_exp.h = v.exp_h; cur_exp.err = v.exp_err;
    vs0 = v.vs_line * HT + v.vs_px;
    for (int ln = 0; ln < VT; ln++) begin
      for (int h = 0; h < HT; h++) begin
        if (stop_after >= 0 && n >= stop_after) return;
        pos = ln * HT + h;
        len = (ln == v.short_idx) ? v.short_len : HA;
        de  = (ln < v.n_lines) && (ln <= v.vs_line) && (h < len);
        vs  = (pos >= vs0) && (pos < vs0 + 2 * HT);
        hs  = (h >= HA + 2 && h < HA + 5) || (ln == v.hs_idx && h == HA / 2);
        lnb = ln[3:0];
        hb  = h[3:0];
        step(1'b1, hs, vs, de, v.solid ? 12'h0F3 : {lnb, hb, 4'h5});
        n++;
      end
    end
  endtask

  function automatic frame_vec_t mk(int nl, int si, int sl, int vl, int vp, int hi, bit so,
                                    int ed, bit cw, int ew, int eh, bit ee);
    frame_vec_t v;
    v.n_lines = nl; v.short_idx = si; v.short_len = sl; v.vs_line = vl; v.vs_px = vp;
    v.hs_idx = hi; v.solid = so; v.exp_done = ed; v.chk_w = cw; v.exp_w = ew;
    v.exp_h = eh; v.exp_err = ee;
    return v;
  endfunction

  task automatic check_all_zero();
    chk("rst_rx_sx", 32'(rx_sx), 0);
    chk("rst_rx_sy", 32'(rx_sy), 0);
    chk("rst_rx_de", 32'(rx_de), 0);
    chk("rst_rx_rgb", 32'(rx_rgb), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_w", 32'(frame_w), 0);
    chk("rst_frame_h", 32'(frame_h), 0);
    chk("rst_geom_err", 32'(geom_err), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_frame_sum", frame_sum, 0);
  endtask

  task automatic run_vec(input frame_vec_t v, input string name);
    int d0;
    d0 = done_seen;
    gen_frame(v, -1);
    chk(name, done_seen - d0, v.exp_done);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_vec_t vec[12];
    frame_vec_t nom;
    int d0;
    nom = mk(VA, -1, 0, VA + 1, 0, -1, 1'b0, 1, 1'b1, HA, VA, 1'b0);
    vec[0]  = mk(VA, -1, 0, VA + 1, 0, -1, 1'b0, 0, 1'b1, HA, VA, 1'b0);
    vec[1]  = mk(VA, -1, 0, VA + 1, 0, -1, 1'b1, 1, 1'b1, HA, VA, 1'b0);
    vec[2]  = nom;
    vec[3]  = mk(VA, 3, HA - 1, VA + 1, 0, -1, 1'b0, 1, 1'b1, HA, VA, 1'b1);
    vec[4]  = nom;
    vec[5]  = mk(VA - 1, -1, 0, VA + 1, 0, -1, 1'b0, 1, 1'b1, HA, VA - 1, 1'b1);
    vec[6]  = mk(VA, -1, 0, 5, 10, -1, 1'b0, 1, 1'b1, HA, 5, 1'b1);
    vec[7]  = nom;
    vec[8]  = mk(VA, -1, 0, VA + 1, 0, 2, 1'b0, 1, 1'b1, HA, VA, 1'b1);
    vec[9]  = mk(VA, -1, 0, VA - 1, HA, -1, 1'b0, 1, 1'b1, HA, VA, 1'b0);
    vec[10] = mk(0, -1, 0, VA + 1, 0, -1, 1'b0, 1, 1'b0, 0, 0, 1'b1);
    vec[11] = nom;

    model_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
    check_all_zero();

    for (int i = 0; i < 12; i++) run_vec(vec[i], $sformatf("done_count_vec%0d", i));

    // Reset in the middle of a frame: partial frame dropped, re-arm on next vsync.
    gen_frame(nom, 3 * HT + 7);
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
    check_all_zero();
    run_vec(vec[0], "done_count_after_rst");
    run_vec(nom, "done_count_relock");

    // Over-long line (sx saturation) followed by too many lines (sy / line-count saturation).
    cur_exp.chk_w = 1'b1; cur_exp.w = 1; cur_exp.h = 1023; cur_exp.err = 1'b1;
    d0 = done_seen;
    for (int i = 0; i < 2050; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 12'h0F3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    for (int i = 0; i < 1025; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 12'h0F3);
      step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    chk("done_count_saturated", done_seen - d0, 1);
    run_vec(nom, "done_count_final");

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    chk("pending_frames", fq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
